vga_board_renderer: RTL and testbench
=====================================

Name: vga_board_renderer

Overview:
- Downstream consumer of the state manager's `VGA_frame`. Generates 640x480@60 VGA timing and renders the game board as a cell grid in 12-bit RGB.
- Emits the `VGA_new_frame_ready` pulse that gates the state manager's frame swap.
- Takes a snapshot of the frame once per frame so that a swap cannot tear the displayed image.

Parameters:
- ROWS, 20, board rows; row 0 is drawn at the top.
- COLS, 10, board columns; column 0 is drawn at the left.
- CELL_LOG2, 4, log2 of the cell edge in pixels (16 px cells).
- X0, 240, left pixel of the board.
- Y0, 80, top line of the board.
- EMPTY_RGB, 12'h222, colour of an unoccupied cell.
- FILL_RGB, 12'h0F0, colour of an occupied cell.
- BG_RGB, 12'h000, colour of visible pixels outside the board.

Ports:
- clk  in  1  pixel clock, 25.175 MHz; one pixel per cycle.
- reset  in  1  synchronous, active-high.
- VGA_frame  in  game_state_pkg::game_state_t  current frame; its `board` field is packed [ROWS-1:0][COLS-1:0], 1 = occupied.
- VGA_new_frame_ready  out  1  one-cycle pulse at the start of vertical blanking.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}.
- hcount  out  10  stage-0 horizontal counter, for debug.
- vcount  out  10  stage-0 vertical counter, for debug.

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-high (`reset`).
- Reset values:
  - hcount=0, vcount=0.
  - hsync=1, vsync=1, rgb=0.
  - VGA_new_frame_ready=0.
  - snapshot board = all zeros.
  - pipeline valid/blank bits = blank.
- Horizontal timing: 800 counts. Visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing: 525 lines. Visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Counter update: hcount increments every cycle and wraps 799->0. vcount increments when hcount wraps, and wraps 524->0.
- VGA_new_frame_ready: high exactly for the cycle where stage 0 has (hcount=0, vcount=480). This gives one pulse per frame, with about 45 lines of guaranteed blanking before the next visible pixel.
- Snapshot: on the cycle stage 0 has (hcount=0, vcount=524), the register `snap <= VGA_frame.board`. Rendering uses only `snap`, so a frame change mid-visible-region never alters the displayed image until the next snapshot.
- Pipeline: 2 stages; latency 2 cycles from counter value to rgb/hsync/vsync.
  - S1 registers visible = (h<640 && v<480) and in_board = (h-X0)<(COLS<<CELL_LOG2) && (v-Y0)<(ROWS<<CELL_LOG2). The subtraction is 11-bit unsigned, so negative offsets fail the compare.
  - S1 also registers col=(h-X0)>>CELL_LOG2 and row=(v-Y0)>>CELL_LOG2, plus the sync levels.
  - S2 output: rgb = !visible ? 0 : !in_board ? BG_RGB : snap[row][col] ? FILL_RGB : EMPTY_RGB. S2 also registers the sync levels delayed by the same amount.
  - hsync and vsync are delayed identically to rgb, so pixel-to-sync alignment is exact.
- Reset mid-frame: all counters and pipeline stages clear on the next edge, outputs return to reset values, and no frame_ready pulse is emitted until vcount next reaches 480.
- No out-of-range indexing: row/col are used only when in_board=1.

Optional Feature:
- GRID_LINES_EN defined:
  - Any in-board pixel whose in-cell x offset or y offset equals 0 renders 12'h444, regardless of occupancy. Occupied cells therefore show a 1-px outline.
  - The in-cell offsets are the low CELL_LOG2 bits of h-X0 / v-Y0.
  - The offset bits are carried through S1; latency is unchanged.
- GRID_LINES_EN undefined: cells are solid EMPTY_RGB/FILL_RGB, and the offset bits are not generated.

Test Plan:
- Reset, then release; run 800*525 cycles.
  - Exactly one VGA_new_frame_ready pulse, at (h=0,v=480).
  - hsync low for 96 cycles per line.
  - vsync low for 2 lines, starting at line 490 (pipeline-shifted by 2).
- board[0][0]=1, all other cells 0; snapshot taken; next frame:
  - pixel (240,80) -> rgb=12'h0F0, 2 cycles after counter=(240,80).
  - pixel (256,80) -> 12'h222.
  - pixel (239,80) -> 12'h000.
- board[19][9]=1:
  - pixel (399,399) -> 12'h0F0.
  - pixel (400,399) -> 12'h000.
  - pixel (399,400) -> 12'h000.
- VGA_frame changed at (h=100,v=200) mid-frame: remaining visible lines keep the old image; the new image appears only after the snapshot at v=524.
- Assert reset at (h=500,v=300) for 1 cycle:
  - next cycle hcount=0, vcount=0, rgb=0, hsync=vsync=1.
  - next pulse occurs 480*800 cycles later.
- With GRID_LINES_EN and board[0][0]=1: (240,80) -> 12'h444, (241,81) -> 12'h0F0; without the macro, (240,80) -> 12'h0F0.

Source files
------------

// File: rtl/vga_board_renderer.sv
// 640x480@60 VGA timing plus a 2-stage board renderer that draws a snapshot of the game board.
// Optional GRID_LINES_EN draws a 1-px grid (12'h444) on the top/left edge of every board cell.
package game_state_pkg;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;

  typedef struct packed {
    logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board;
  } game_state_t;
endpackage

module vga_board_renderer #(
  parameter int          ROWS      = 20,
  parameter int          COLS      = 10,
  parameter int          CELL_LOG2 = 4,
  parameter int          X0        = 240,
  parameter int          Y0        = 80,
  parameter logic [11:0] EMPTY_RGB = 12'h222,
  parameter logic [11:0] FILL_RGB  = 12'h0F0,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter int          H_VIS     = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VIS     = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  input  game_state_pkg::game_state_t VGA_frame,
  output logic                        VGA_new_frame_ready,
  output logic                        hsync,
  output logic                        vsync,
  output logic [11:0]                 rgb,
  output logic [9:0]                  hcount,
  output logic [9:0]                  vcount
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_VIS + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_VIS + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);

  // ---------------- stage 0: counters ----------------
  logic [9:0] r_h, r_v;
  logic [9:0] w_h_nxt, w_v_nxt;
  logic       r_rdy;

  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == 10'(H_TOTAL - 1)) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
    end
  end

  // Pulse is decoded from next-state so it is high while stage 0 sits at (0, V_VIS).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h   <= '0;
      r_v   <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_h   <= w_h_nxt;
      r_v   <= w_v_nxt;
      r_rdy <= (w_h_nxt == '0) && (w_v_nxt == 10'(V_VIS));
    end
  end

  assign hcount              = r_h;
  assign vcount              = r_v;
  assign VGA_new_frame_ready = r_rdy;

  // ---------------- snapshot ----------------
  logic [ROWS-1:0][COLS-1:0] r_snap;

  always_ff @(posedge clk) begin
    if (reset)
      r_snap <= '0;
    else if (r_h == '0 && r_v == 10'(V_TOTAL - 1))
      r_snap <= VGA_frame.board;
  end

  // ---------------- stage 1: geometry ----------------
  logic [10:0] w_dx, w_dy;
  logic        w_vis, w_inb, w_hs, w_vs;

  // 11-bit unsigned offsets: pixels left of / above the board wrap large and fail the compare.
  assign w_dx  = {1'b0, r_h} - 11'(X0);
  assign w_dy  = {1'b0, r_v} - 11'(Y0);
  assign w_inb = (w_dx < 11'(COLS << CELL_LOG2)) && (w_dy < 11'(ROWS << CELL_LOG2));
  assign w_vis = (r_h < 10'(H_VIS)) && (r_v < 10'(V_VIS));
  assign w_hs  = !((r_h >= 10'(H_SS)) && (r_h < 10'(H_SE)));
  assign w_vs  = !((r_v >= 10'(V_SS)) && (r_v < 10'(V_SE)));

  logic          r1_vis, r1_inb, r1_hs, r1_vs;
  logic [RW-1:0] r1_row;
  logic [CW-1:0] r1_col;
`ifdef GRID_LINES_EN
  logic [CELL_LOG2-1:0] r1_ox, r1_oy;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_vis <= 1'b0;
      r1_inb <= 1'b0;
      r1_hs  <= 1'b1;
      r1_vs  <= 1'b1;
      r1_row <= '0;
      r1_col <= '0;
`ifdef GRID_LINES_EN
      r1_ox  <= '0;
      r1_oy  <= '0;
`endif
    end else begin
      r1_vis <= w_vis;
      r1_inb <= w_inb;
      r1_hs  <= w_hs;
      r1_vs  <= w_vs;
      // Indices are zeroed outside the board so the snapshot lookup never goes out of range.
      r1_row <= w_inb ? RW'(w_dy >> CELL_LOG2) : '0;
      r1_col <= w_inb ? CW'(w_dx >> CELL_LOG2) : '0;
`ifdef GRID_LINES_EN
      r1_ox  <= w_dx[CELL_LOG2-1:0];
      r1_oy  <= w_dy[CELL_LOG2-1:0];
`endif
    end
  end

  // ---------------- stage 2: colour ----------------
  logic [11:0] w_pix;

  always_comb begin
    w_pix = EMPTY_RGB;
    if (!r1_vis)
      w_pix = 12'h000;
    else if (!r1_inb)
      w_pix = BG_RGB;
`ifdef GRID_LINES_EN
    else if (r1_ox == '0 || r1_oy == '0)
      w_pix = 12'h444;
`endif
    else if (r_snap[r1_row][r1_col])
      w_pix = FILL_RGB;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= w_pix;
      hsync <= r1_hs;
      vsync <= r1_vs;
    end
  end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer on a scaled-down timing/board geometry (80x56 frame, 2-px cells).
module tb_vga_board_renderer;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 48, VF = 2, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;   // 80
  localparam int VT = VV + VF + VS + VB;   // 56
  localparam int FRAME = HT * VT;          // 4480
  localparam int X0 = 24, Y0 = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  game_state_pkg::game_state_t frame;
  logic                        rdy, hs, vs;
  logic [11:0]                 rgb;
  logic [9:0]                  hc, vc;

  int n_tests = 0;
  int n_fail  = 0;

  vga_board_renderer #(
    .ROWS(20), .COLS(10), .CELL_LOG2(1), .X0(X0), .Y0(Y0),
    .EMPTY_RGB(12'h222), .FILL_RGB(12'h0F0), .BG_RGB(12'h000),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .VGA_frame(frame),
    .VGA_new_frame_ready(rdy), .hsync(hs), .vsync(vs),
    .rgb(rgb), .hcount(hc), .vcount(vc)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(hc == 10'(h) && vc == 10'(v)) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) begin
      n_tests++; n_fail++;
      $display("FAIL goto: position (%0d,%0d) never reached, stuck at (%0d,%0d)", h, v, hc, vc);
    end
  endtask

  task automatic load_board(input logic [19:0][9:0] b);
    frame.board = b;
    goto(0, VT - 1);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    frame = '0;
    repeat (3) @(negedge clk);
    n_tests += 6;
    if (hc !== 10'd0)   begin n_fail++; $display("FAIL reset_hcount: got %0d want 0", hc); end
    if (vc !== 10'd0)   begin n_fail++; $display("FAIL reset_vcount: got %0d want 0", vc); end
    if (hs !== 1'b1)    begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hs); end
    if (vs !== 1'b1)    begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vs); end
    if (rgb !== 12'h0)  begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    if (rdy !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy); end
    reset = 1'b0;
  endtask

  // One full frame starting at counter (0,0) right after reset release.
  task automatic test_timing;
    int pulses = 0, hs_low = 0, vs_low = 0;
    int ph = -1, pv = -1, vsh = -1, vsv = -1, hsh = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (rdy === 1'b1) begin pulses++; ph = int'(hc); pv = int'(vc); end
      if (hs === 1'b0) begin
        hs_low++;
        if (hsh < 0) hsh = int'(hc);
      end
      if (vs === 1'b0) begin
        vs_low++;
        if (vsh < 0) begin vsh = int'(hc); vsv = int'(vc); end
      end
      @(negedge clk);
    end
    n_tests += 7;
    if (pulses != 1)       begin n_fail++; $display("FAIL ready_count: got %0d want 1", pulses); end
    if (ph != 0 || pv != VV) begin n_fail++; $display("FAIL ready_pos: got (%0d,%0d) want (0,%0d)", ph, pv, VV); end
    if (hs_low != HS * VT) begin n_fail++; $display("FAIL hsync_low_cycles: got %0d want %0d", hs_low, HS * VT); end
    if (hsh != HV + HF + 2) begin n_fail++; $display("FAIL hsync_first_low_h: got %0d want %0d", hsh, HV + HF + 2); end
    if (vs_low != VS * HT) begin n_fail++; $display("FAIL vsync_low_cycles: got %0d want %0d", vs_low, VS * HT); end
    if (vsh != 2)          begin n_fail++; $display("FAIL vsync_first_low_h: got %0d want 2", vsh); end
    if (vsv != VV + VF)    begin n_fail++; $display("FAIL vsync_first_low_v: got %0d want %0d", vsv, VV + VF); end
  endtask

  task automatic test_pixels_top_left;
    logic [19:0][9:0] b = '0;
    b[0][0] = 1'b1;
    load_board(b);
    goto(X0, Y0); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL px_cell00: got %h want 0f0", rgb); end
    goto(X0 + 2, Y0); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h222) begin n_fail++; $display("FAIL px_cell01: got %h want 222", rgb); end
    goto(X0 - 1, Y0); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL px_left_of_board: got %h want 000", rgb); end
  endtask

  task automatic test_pixels_bottom_right;
    logic [19:0][9:0] b = '0;
    b[19][9] = 1'b1;
    load_board(b);
    goto(X0 + 19, Y0 + 39); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL px_cell_19_9: got %h want 0f0", rgb); end
    goto(X0 + 20, Y0 + 39); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL px_right_of_board: got %h want 000", rgb); end
    goto(X0 + 19, Y0 + 40); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL px_below_board: got %h want 000", rgb); end
  endtask

  task automatic test_grid;
    logic [19:0][9:0] b = '0;
    logic [11:0] exp_edge;
`ifdef GRID_LINES_EN
    exp_edge = 12'h444;
`else
    exp_edge = 12'h0F0;
`endif
    b[0][0] = 1'b1;
    load_board(b);
    goto(X0, Y0); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== exp_edge) begin n_fail++; $display("FAIL grid_edge: got %h want %h", rgb, exp_edge); end
    goto(X0 + 1, Y0 + 1); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL grid_inner: got %h want 0f0", rgb); end
  endtask

  task automatic test_snapshot;
    logic [19:0][9:0] a = '0;
    logic [19:0][9:0] b = '0;
    a[0][0] = 1'b1;
    b[19][9] = 1'b1;
    load_board(a);
    goto(10, 20);
    frame.board = b;
    goto(X0 + 19, Y0 + 39); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h222) begin n_fail++; $display("FAIL snap_old_image_19_9: got %h want 222", rgb); end
    goto(0, VT - 1); @(negedge clk);
    goto(X0, Y0); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h222) begin n_fail++; $display("FAIL snap_new_image_00: got %h want 222", rgb); end
    goto(X0 + 19, Y0 + 39); repeat (2) @(negedge clk); n_tests++;
    if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL snap_new_image_19_9: got %h want 0f0", rgb); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    load_board('1);
    goto(30, 30); n_tests++;
    if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL pre_reset_rgb: got %h want 0f0", rgb); end
    reset = 1'b1;
    @(negedge clk);
    n_tests += 6;
    if (hc !== 10'd0)  begin n_fail++; $display("FAIL mid_reset_hcount: got %0d want 0", hc); end
    if (vc !== 10'd0)  begin n_fail++; $display("FAIL mid_reset_vcount: got %0d want 0", vc); end
    if (rgb !== 12'h0) begin n_fail++; $display("FAIL mid_reset_rgb: got %h want 000", rgb); end
    if (hs !== 1'b1)   begin n_fail++; $display("FAIL mid_reset_hsync: got %b want 1", hs); end
    if (vs !== 1'b1)   begin n_fail++; $display("FAIL mid_reset_vsync: got %b want 1", vs); end
    if (rdy !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", rdy); end
    reset = 1'b0;
    while (rdy !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != VV * HT) begin n_fail++; $display("FAIL ready_after_reset: got %0d cycles want %0d", n, VV * HT); end
  endtask

  initial begin
    test_reset;
    test_timing;
    test_pixels_top_left;
    test_pixels_bottom_right;
    test_grid;
    test_snapshot;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
